// File: rtl/splitmix64_pkg.sv
// rtl/splitmix64_pkg.sv - shared SplitMix64 constants and unmix FSM states
package splitmix64_pkg;

  localparam logic [63:0] GAMMA  = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] M1     = 64'hBF58476D1CE4E5B9;
  localparam logic [63:0] M2     = 64'h94D049BB133111EB;
  localparam logic [63:0] INV_M1 = 64'h96DE1B173F119089;
  localparam logic [63:0] INV_M2 = 64'h319642B2D24D8EC3;

  localparam int SHIFT1 = 30;
  localparam int SHIFT2 = 27;
  localparam int SHIFT3 = 31;

  typedef enum logic [2:0] {
    IDLE,
    UX31,
    MUL2,
    UX27,
    MUL1,
    UX30,
    SEED,
    HOLD
  } unmix_state_t;

endpackage

// File: rtl/splitmix64_unxorshift.sv
// rtl/splitmix64_unxorshift.sv - inverse of z ^= z >> SHIFT on a 64-bit word
module splitmix64_unxorshift #(
  parameter int SHIFT = 31
) (
  input  logic [63:0] x,
  output logic [63:0] y
);

  // x ^ x>>S ^ x>>2S ... undoes the xorshift for every multiple of S below 64
  always_comb begin
    y = x;
    for (int k = 1; k * SHIFT < 64; k++) begin
      y = y ^ (x >> (k * SHIFT));
    end
  end

endmodule

// File: rtl/splitmix64_unmix.sv
// rtl/splitmix64_unmix.sv - iterative inverse of the SplitMix64 mixer with seed recovery
module splitmix64_unmix
  import splitmix64_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_word,
  input  logic [63:0] in_idx,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_state,
  output logic [63:0] res_seed
);

  unmix_state_t state;
  logic [63:0]  w;
  logic [63:0]  idx;
  logic [63:0]  ux31;
  logic [63:0]  ux27;
  logic [63:0]  ux30;
  logic [63:0]  mul_a;
  logic [63:0]  mul_b;
  logic [63:0]  prod;

  splitmix64_unxorshift #(.SHIFT(SHIFT3)) u_ux31 (.x(w), .y(ux31));
  splitmix64_unxorshift #(.SHIFT(SHIFT2)) u_ux27 (.x(w), .y(ux27));
  splitmix64_unxorshift #(.SHIFT(SHIFT1)) u_ux30 (.x(w), .y(ux30));

  // One multiplier serves both inverse multiplies and the idx*GAMMA term
  always_comb begin
    mul_a = w;
    mul_b = INV_M2;
    case (state)
      MUL1: mul_b = INV_M1;
      SEED: begin
        mul_a = idx;
        mul_b = GAMMA;
      end
      default: ;
    endcase
  end

  assign prod     = mul_a * mul_b;
  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      w         <= '0;
      idx       <= '0;
      res_valid <= 1'b0;
      res_state <= '0;
      res_seed  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            w     <= in_word;
            idx   <= in_idx;
            state <= UX31;
          end
        end
        UX31: begin
          w     <= ux31;
          state <= MUL2;
        end
        MUL2: begin
          w     <= prod;
          state <= UX27;
        end
        UX27: begin
          w     <= ux27;
          state <= MUL1;
        end
        MUL1: begin
          w     <= prod;
          state <= UX30;
        end
        UX30: begin
          w     <= ux30;
          state <= SEED;
        end
        SEED: begin
          res_state <= w;
          res_seed  <= w - prod;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_splitmix64_unmix.sv
// tb/tb_splitmix64_unmix.sv - directed and round-trip checks for splitmix64_unmix
module tb_splitmix64_unmix;

  localparam logic [63:0] TB_GAMMA = 64'h9E3779B97F4A7C15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_word;
  logic [63:0] in_idx;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_state;
  logic [63:0] res_seed;

  int n_checks = 0;
  int n_fail   = 0;

  splitmix64_unmix dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_idx    (in_idx),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_state (res_state),
    .res_seed  (res_seed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference generator mixer, written forward from the algorithm definition
  function automatic logic [63:0] mix(input logic [63:0] z_in);
    logic [63:0] z;
    z = z_in;
    z = (z ^ (z >> 30)) * 64'hBF58476D1CE4E5B9;
    z = (z ^ (z >> 27)) * 64'h94D049BB133111EB;
    return z ^ (z >> 31);
  endfunction

  task automatic run_req(input string tag, input logic [63:0] word, input logic [63:0] idx,
                         input logic [63:0] exp_state, input logic [63:0] exp_seed,
                         input bit early);
    int budget;
    int lat;
    in_word   = word;
    in_idx    = idx;
    in_valid  = 1'b1;
    res_ready = early;
    budget    = 0;
    while (!in_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    check({tag, "_accept"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd7);
    check({tag, "_state"}, res_state, exp_state);
    check({tag, "_seed"}, res_seed, exp_seed);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_valid_clr"}, 64'(res_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] seed;
    logic [63:0] held_state;
    logic [63:0] held_seed;
    int          fails_before;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    in_idx    = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_state", res_state, 64'd0);
    check("post_rst_seed", res_seed, 64'd0);

    run_req("zero", 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    run_req("known1", 64'hE220A8397B1DCDAF, 64'd1, 64'h9E3779B97F4A7C15, 64'd0, 1'b0);
    run_req("seq2", 64'h6E789E6AA1B965F4, 64'd2, 64'h3C6EF372FE94F82A, 64'd0, 1'b0);
    run_req("seq3", 64'h06C45D188009454F, 64'd3, 64'hDAA66D2C7DDF743F, 64'd0, 1'b0);
    // Early res_ready: result still presented once, then taken on the next edge
    run_req("early", 64'hE220A8397B1DCDAF, 64'd0, 64'h9E3779B97F4A7C15,
            64'h9E3779B97F4A7C15, 1'b1);

    // Back-pressure with a competing request held on the input
    in_word  = 64'hE220A8397B1DCDAF;
    in_idx   = 64'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_word = 64'h6E789E6AA1B965F4;
    in_idx  = 64'd2;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("bp_valid", 64'(res_valid), 64'd1);
    held_state = 64'h9E3779B97F4A7C15;
    held_seed  = 64'd0;
    fails_before = n_fail;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", 64'(res_valid), 64'd1);
      check("bp_hold_state", res_state, held_state);
      check("bp_hold_seed", res_seed, held_seed);
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("bp_release_valid", 64'(res_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("bp_not_accepted", 64'(res_valid), 64'd0);
    check("bp_state_persist", res_state, held_state);
    if (n_fail != fails_before) $display("back-pressure section reported errors");

    // Reset while in MUL1 must drop everything
    in_word  = 64'h06C45D188009454F;
    in_idx   = 64'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(res_valid), 64'd0);
    check("mid_rst_state", res_state, 64'd0);
    check("mid_rst_seed", res_seed, 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_release", 64'(in_ready), 64'd1);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("mid_rst_no_result", 64'(res_valid), 64'd0);
    run_req("after_rst", 64'h06C45D188009454F, 64'd3, 64'hDAA66D2C7DDF743F, 64'd0, 1'b0);

    // Round trip against the forward generator
    seed = {$urandom, $urandom};
    for (int n = 0; n <= 1000; n++) begin
      logic [63:0] st;
      st = seed + 64'(n) * TB_GAMMA;
      run_req("rt", mix(st), 64'(n), st, seed, 1'b0);
    end
    run_req("rt_wrap", mix(seed - TB_GAMMA), 64'hFFFFFFFFFFFFFFFF, seed - TB_GAMMA, seed, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
